// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : memory_responder
// Purpose  : Word-addressed 16-bit memory that answers CPU read/write
//            requests after a fixed, parameterised latency, returning read
//            data on a shared bidirectional bus.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous active-high reset
//   readM          in   read request (must stay high while the read is pending)
//   writeM         in   write request (must stay high while the write is pending)
//   address[15:0]  in   word address, wraps modulo DEPTH
//   data[15:0]     io   write data in; read data out during READ_DONE, else Z
//   inputReady     out  one-cycle pulse, read data valid on data
//   writeDone      out  one-cycle pulse, write committed
//   protocol_error out  sticky, readM and writeM seen together
//   load_en        in   backdoor preload enable (honoured only in idle)
//   load_addr[15:0] in  backdoor preload address
//   load_data[15:0] in  backdoor preload data
// ============================================================================
module memory_responder #(
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readM,
  input  logic        writeM,
  input  logic [15:0] address,
  inout  wire  [15:0] data,
  output logic        inputReady,
  output logic        writeDone,
  output logic        protocol_error,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data
);

  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  // Counter starts at latency-1 so the DONE state is entered exactly
  // LATENCY edges after acceptance.
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_READ_WAIT  = 3'd1,
    S_READ_DONE  = 3'd2,
    S_WRITE_WAIT = 3'd3,
    S_WRITE_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            perr_q, perr_d;

  logic [15:0]     mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [15:0]     mem_wdata;

  logic            can_accept;
  logic            accept_rd;
  logic            accept_wr;
  logic            both_req;

  // Upper address bits are intentionally discarded (modulo-DEPTH wrap).
  generate
    if (AW < 16) begin : g_unused_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^{address[15:AW], load_addr[15:AW]};
    end
  endgenerate

  // The DONE states behave like IDLE on their exit edge so a request held
  // high is re-accepted without an idle gap cycle.
  assign can_accept = (state_q == S_IDLE) || (state_q == S_READ_DONE) ||
                      (state_q == S_WRITE_DONE);
  assign accept_rd  = can_accept && readM && !writeM;
  assign accept_wr  = can_accept && writeM && !readM;
  assign both_req   = can_accept && readM && writeM;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    perr_d    = perr_q | both_req;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;

    case (state_q)
      S_IDLE, S_READ_DONE, S_WRITE_DONE: begin
        state_d = S_IDLE;
        if (accept_rd) begin
          state_d = S_READ_WAIT;
          addr_d  = address[AW-1:0];
          cnt_d   = RD_LOAD;
        end else if (accept_wr) begin
          state_d = S_WRITE_WAIT;
          addr_d  = address[AW-1:0];
          wdata_d = data;
          cnt_d   = WR_LOAD;
        end else if ((state_q == S_IDLE) && load_en) begin
          mem_we    = 1'b1;
          mem_waddr = load_addr[AW-1:0];
          mem_wdata = load_data;
        end
      end
      S_READ_WAIT: begin
        if (!readM) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_READ_DONE;
          rdata_d = mem[addr_q];
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WRITE_WAIT: begin
        if (!writeM) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_WRITE_DONE;
          mem_we  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      perr_q  <= perr_d;
    end
  end

  // Array has no reset; a write is suppressed on a reset edge so an
  // in-flight access never lands.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign inputReady     = (state_q == S_READ_DONE);
  assign writeDone      = (state_q == S_WRITE_DONE);
  assign protocol_error = perr_q;
  assign data           = (state_q == S_READ_DONE) ? rdata_q : 16'bz;

endmodule
`default_nettype wire
